// File: rtl/popcount_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : popcount_sequencer
// Description : Frame-level ones counter. Each accepted DATA_W-bit word is
//               scanned one nibble per clock through a shared 4-bit popcount
//               stage. Counts accumulate (saturating) until the word tagged
//               in_last has been scanned. The frame total is then offered on
//               a valid/ready output together with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    localparam int NIB   = DATA_W / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NIB - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   C_SUM_MAX  = {1'b0, C_CNT_MAX};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_word;
    logic                r_last;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_acc;
    logic                r_ovf;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [3:0]          w_nib;
    logic [2:0]          w_pop;
    logic [CNT_W:0]      w_sum;
    logic                w_sat;

    // Shared popcount stage: select the current nibble and count its ones,
    // then form the one-bit-wider sum so saturation can be detected.
    always_comb begin
        w_nib = r_word[{r_idx, 2'b00} +: 4];
        w_pop = 3'(w_nib[0]) + 3'(w_nib[1]) + 3'(w_nib[2]) + 3'(w_nib[3]);
        w_sum = {1'b0, r_acc} + {{(CNT_W - 2){1'b0}}, w_pop};
        w_sat = (w_sum > C_SUM_MAX);
    end

    // A word offered while clear is high must never be taken.
    assign in_ready     = r_in_ready & ~clear;
    assign out_valid    = r_out_valid;
    assign out_count    = r_acc;
    assign out_overflow = r_ovf;

    // Frame sequencer: accept word, scan its nibbles, present the frame total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_word      <= '0;
            r_last      <= 1'b0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            // Abort wins over everything, including a same-cycle handshake.
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_word     <= in_data;
                        r_last     <= in_last;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_sat) begin
                        r_acc <= C_CNT_MAX;
                        r_ovf <= 1'b1;
                    end else begin
                        r_acc <= w_sum[CNT_W-1:0];
                    end
                    if (r_idx == C_IDX_LAST) begin
                        r_idx <= '0;
                        if (r_last) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_in_ready  <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_popcount_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_sequencer
// Description : Self-checking bench for popcount_sequencer (DATA_W=32,
//               CNT_W=6 so saturation is reachable within a few words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_sequencer;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;
    localparam int MAXC   = (1 << CNT_W) - 1;
    localparam int NIB    = DATA_W / 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  out_count;
    logic              out_overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    popcount_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: frame total is the plain ones count, clipped at MAXC.
    function automatic int ref_count(input int ones);
        return (ones > MAXC) ? MAXC : ones;
    endfunction

    function automatic logic ref_ovf(input int ones);
        return (ones > MAXC);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and hold it until accepted; returns the acceptance edge.
    task automatic send_word(input logic [DATA_W-1:0] d, input logic l, output int acc_cyc);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        #1;
        while (!in_ready && n < 100) begin tick(); n++; end
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL send_timeout: in_ready got %b expected 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(output int k);
        k = 0;
        while (!out_valid && k < 50) begin tick(); k++; end
    endtask

    // Wait for the frame result, check it, and complete the handshake.
    task automatic consume(input int exp_c, input logic exp_o, input string nm);
        int k;
        wait_out(k);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL %s_valid: out_valid got %b expected 1", nm, out_valid);
        else n_pass++;
        n_checks++;
        if (out_count !== CNT_W'(exp_c)) $display("FAIL %s_count: got %0d expected %0d", nm, out_count, exp_c);
        else n_pass++;
        n_checks++;
        if (out_overflow !== exp_o) $display("FAIL %s_ovf: got %b expected %b", nm, out_overflow, exp_o);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s_release: valid/ready got %b/%b expected 0/1", nm, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++;
        if (out_count !== '0) $display("FAIL reset_out_count: got %0d expected 0", out_count); else n_pass++;
        n_checks++;
        if (out_overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", out_overflow); else n_pass++;
    endtask

    task automatic test_single();
        int t0, k;
        send_word(32'hFFFF_FFFF, 1'b1, t0);
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL single_busy: in_ready got %b expected 0", in_ready); else n_pass++;
        wait_out(k);
        n_checks++;
        if (k !== NIB) $display("FAIL single_latency: got %0d expected %0d", k, NIB); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL single_done_ready: got %b expected 0", in_ready); else n_pass++;
        consume(32, 1'b0, "single");
    endtask

    task automatic test_multi_word();
        int t0, t1, t2, k;
        send_word(32'h0000_000F, 1'b0, t0);
        k = 0;
        while (!in_ready && k < 50) begin tick(); k++; end
        n_checks++;
        if (k !== NIB) $display("FAIL multi_ready_return: got %0d expected %0d", k, NIB); else n_pass++;
        send_word(32'h8000_0001, 1'b0, t1);
        n_checks++;
        if (t1 - t0 !== NIB + 1) $display("FAIL multi_spacing1: got %0d expected %0d", t1 - t0, NIB + 1); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL multi_ready_pulse: got %b expected 0", in_ready); else n_pass++;
        send_word(32'h1234_5678, 1'b1, t2);
        n_checks++;
        if (t2 - t1 !== NIB + 1) $display("FAIL multi_spacing2: got %0d expected %0d", t2 - t1, NIB + 1); else n_pass++;
        consume(19, 1'b0, "multi");
    endtask

    task automatic test_backpressure();
        int t0, k;
        send_word(32'h0000_0003, 1'b1, t0);
        wait_out(k);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_count !== CNT_W'(2) || in_ready !== 1'b0)
                $display("FAIL bp_hold: valid/count/ready got %b/%0d/%b expected 1/2/0",
                         out_valid, out_count, in_ready);
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== '0)
            $display("FAIL bp_release: valid/ready/count got %b/%b/%0d expected 0/1/0",
                     out_valid, in_ready, out_count);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int t;
        int ones;
        ones = 0;
        for (int i = 0; i < 3; i++) begin
            send_word(32'hFFFF_FFFF, (i == 2), t);
            ones += 32;
        end
        consume(ref_count(ones), ref_ovf(ones), "sat");
        send_word(32'h0000_0001, 1'b1, t);
        consume(1, 1'b0, "sat_next");
    endtask

    task automatic test_clear();
        int t;
        send_word(32'hFFFF_FFFF, 1'b1, t);
        tick(); tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== '0 || out_overflow !== 1'b0)
            $display("FAIL clear_scan: ready/valid/count/ovf got %b/%b/%0d/%b expected 1/0/0/0",
                     in_ready, out_valid, out_count, out_overflow);
        else n_pass++;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL clear_no_done: out_valid got %b expected 0", out_valid); else n_pass++;
        in_valid = 1'b1; in_data = 32'h0000_00FF; in_last = 1'b1; clear = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL clear_gates_ready: got %b expected 0", in_ready); else n_pass++;
        tick();
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL clear_no_accept: in_ready got %b expected 1", in_ready); else n_pass++;
        send_word(32'h0000_0010, 1'b1, t);
        consume(1, 1'b0, "clear_next");
    endtask

    task automatic test_clear_handshake();
        int t, k;
        send_word(32'h0000_0007, 1'b1, t);
        wait_out(k);
        out_ready = 1'b1; clear = 1'b1;
        tick();
        out_ready = 1'b0; clear = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_count !== '0 || in_ready !== 1'b1)
            $display("FAIL clear_hs: valid/count/ready got %b/%0d/%b expected 0/0/1",
                     out_valid, out_count, in_ready);
        else n_pass++;
        send_word(32'h0000_0003, 1'b1, t);
        consume(2, 1'b0, "clear_hs_next");
    endtask

    task automatic test_async_reset();
        int t;
        send_word(32'hFFFF_FFFF, 1'b1, t);
        tick(); tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== '0 || out_overflow !== 1'b0)
            $display("FAIL async_reset: ready/valid/count/ovf got %b/%b/%0d/%b expected 1/0/0/0",
                     in_ready, out_valid, out_count, out_overflow);
        else n_pass++;
        #2;
        rst_n = 1'b1;
        tick();
        send_word(32'hF0F0_F0F0, 1'b1, t);
        consume(16, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        int t, k, nw, ones, hold;
        logic [DATA_W-1:0] d;
        for (int f = 0; f < 25; f++) begin
            nw = $urandom_range(1, 3);
            ones = 0;
            for (int w = 0; w < nw; w++) begin
                d = $urandom;
                if ($urandom_range(0, 3) == 0) d = d & 32'h0F00_F00F;
                ones += $countones(d);
                send_word(d, (w == nw - 1), t);
            end
            wait_out(k);
            n_checks++;
            if (k !== NIB) $display("FAIL rand_latency: got %0d expected %0d", k, NIB); else n_pass++;
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) tick();
            consume(ref_count(ones), ref_ovf(ones), "rand");
        end
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        tick();
        test_reset();
        test_single();
        test_multi_word();
        test_backpressure();
        test_saturation();
        test_clear();
        test_clear_handshake();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
